step_tracker: RTL
=================

// Module: step_tracker
// PURPOSE
//  Downstream consumer of the step-pulse generator: each rising edge of its pulse output is one step.
//  Keeps the fitness statistics shown on the display mux:
//   - total steps
//   - distance in half-miles
//   - count of the first WINDOW_SEC seconds with more than OVER_RATE steps
//   - cumulative high-activity time
//  Pure sequential stats engine; no display formatting.
// PARAMETERS
//  CLK_HZ      100_000_000  pulseBase frequency; one-second timebase period (bench uses 100)
//  STEP_SAT    9999         saturation value of stepCount
//  HALF_MILE   1024         steps per half-mile distance increment
//  WINDOW_SEC  9            length of initial over-rate observation window, seconds
//  OVER_RATE   32           steps/sec strictly above which a window second counts
//  HI_RATE     64           steps/sec at or above which a second is high-activity
//  HI_MIN_SEC  60           consecutive high seconds before a run qualifies
// PORTS
//  pulseBase     in   1   system clock, all logic on rising edge
//  resetN        in   1   synchronous reset, active-low
//  pulseIn       in   1   step pulse from generator, same clock domain, level signal
//  stepCount     out  14  total steps, saturating at STEP_SAT
//  distHalfMiles out  6   distance in 0.5-mile units, saturating at 63
//  overSecs      out  4   window seconds with steps > OVER_RATE, max WINDOW_SEC
//  hiActSecs     out  16  total seconds spent in qualified high-activity runs, saturating 65535
//  secTick       out  1   one-cycle strobe on the last cycle of each second
// BEHAVIOUR
//  Reset (resetN low at a pulseBase edge):
//   - all outputs, counters and timebase go to 0; FSM to IDLE
//   - edge-detect flop loads 1, so pulseIn high at release is NOT a step
//   - reset mid-operation discards all partial state on the next edge
//  Timebase: counter 0..CLK_HZ-1; secTick=1 when counter==CLK_HZ-1, then wraps to 0.
//  Step detect: stepEdge = pulseIn & ~pulseIn_q.
//   - stepCount updates on the edge after pulseIn is first sampled high (1-cycle latency)
//   - at STEP_SAT, further steps are ignored by stepCount only; distance/rate logic still counts
//  Distance:
//   - internal 10-bit residue counter; on step with residue==HALF_MILE-1, residue->0 and distHalfMiles+1
//   - distHalfMiles holds at 63
//  Per-second count secSteps (8 b, sat 255):
//   - secTotal = secSteps + stepEdge, i.e. a step coincident with secTick belongs to the ending second
//   - on secTick: secSteps->0; otherwise secSteps += stepEdge
//  Window: secIdx (4 b) increments on secTick, saturating at WINDOW_SEC.
//   - on secTick with secIdx<WINDOW_SEC and secTotal>OVER_RATE: overSecs+1
//  High-activity FSM, evaluated only on secTick; runLen 16 b sat:
//   - IDLE:    secTotal>=HI_RATE -> runLen=1, PENDING (ACTIVE directly if HI_MIN_SEC==1)
//   - PENDING: high -> runLen+1; if runLen+1==HI_MIN_SEC: hiActSecs+=HI_MIN_SEC, -> ACTIVE
//              low  -> runLen=0, IDLE; no credit
//   - ACTIVE:  high -> hiActSecs+1; low -> runLen=0, IDLE; hiActSecs holds
//   - hiActSecs add saturates at 65535
//  Between secTicks, overSecs, hiActSecs and FSM state are stable.
// STRUCTURE
//  step_tracker_pkg: FSM state enum (IDLE, PENDING, ACTIVE), output widths, saturation constants.
//  Sub-module sec_timebase (CLK_HZ param; pulseBase, resetN -> secTick): one-second strobe generator.
//  Remainder (edge detect, counters, FSM) stays flat in step_tracker.
// TESTING (CLK_HZ=100)
//  1. Hold pulseIn=1 through reset release, keep high 50 cycles -> stepCount=0, all outputs 0.
//  2. 10 pulses, 2 cycles high / 3 low -> stepCount increments 1 cycle after each rise, final 10.
//  3. 10005 pulses -> stepCount=9999, distHalfMiles=9.
//  4. 40 steps/s for 12 s -> overSecs 1..9 on ticks 1..9, stays 9.
//     Then 32 steps + 1 step on the secTick cycle in a window second -> counted as 33 (fresh run after reset).
//  5. 64 steps/s:
//     - after 59 ticks, hiActSecs=0
//     - tick 60 -> 60, tick 61 -> 61
//     - one second of 63 steps -> IDLE, hiActSecs holds 61
//  6. Assert resetN low for 1 cycle mid-PENDING (runLen=30)
//     -> all outputs 0, IDLE; a further 59 high seconds give hiActSecs=0.

Source files
------------

// File: rtl/step_tracker_pkg.sv
// Shared types, widths and saturation limits for the step statistics engine.
package step_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACTIVE  = 2'd2
  } hi_state_t;

  localparam int STEP_W = 14;
  localparam int DIST_W = 6;
  localparam int OVER_W = 4;
  localparam int HI_W   = 16;
  localparam int RES_W  = 10;
  localparam int SEC_W  = 8;
  localparam int TOT_W  = SEC_W + 1;
  localparam int RUN_W  = 16;

  function automatic logic [HI_W-1:0] sat_add_hi(input logic [HI_W-1:0] a,
                                                 input logic [HI_W-1:0] b);
    logic [HI_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[HI_W] ? {HI_W{1'b1}} : sum[HI_W-1:0];
  endfunction

endpackage

// File: rtl/sec_timebase.sv
// One-second strobe: counts 0..CLK_HZ-1 and asserts secTick on the last cycle of each second.
module sec_timebase #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic pulseBase,
  input  logic resetN,
  output logic secTick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge pulseBase) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign secTick = (cnt == LAST);

endmodule

// File: rtl/step_tracker.sv
// Fitness statistics from step-pulse rising edges: total steps, half-miles,
// early over-rate seconds and time spent in qualified high-activity runs.
module step_tracker
  import step_tracker_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int STEP_SAT   = 9999,
  parameter int HALF_MILE  = 1024,
  parameter int WINDOW_SEC = 9,
  parameter int OVER_RATE  = 32,
  parameter int HI_RATE    = 64,
  parameter int HI_MIN_SEC = 60
) (
  input  logic              pulseBase,
  input  logic              resetN,
  input  logic              pulseIn,
  output logic [STEP_W-1:0] stepCount,
  output logic [DIST_W-1:0] distHalfMiles,
  output logic [OVER_W-1:0] overSecs,
  output logic [HI_W-1:0]   hiActSecs,
  output logic              secTick
);

  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_SAT);
  localparam logic [RES_W-1:0]  RES_LAST = RES_W'(HALF_MILE - 1);
  localparam logic [OVER_W-1:0] WIN_LEN  = OVER_W'(WINDOW_SEC);
  localparam logic [TOT_W-1:0]  OVER_THR = TOT_W'(OVER_RATE);
  localparam logic [TOT_W-1:0]  HI_THR   = TOT_W'(HI_RATE);
  localparam logic [RUN_W-1:0]  RUN_QUAL = RUN_W'(HI_MIN_SEC);
  localparam logic [HI_W-1:0]   HI_CRED  = HI_W'(HI_MIN_SEC);

  logic              pulse_q;
  logic              step_edge;
  logic [RES_W-1:0]  residue;
  logic [SEC_W-1:0]  sec_steps;
  logic [TOT_W-1:0]  sec_total;
  logic [OVER_W-1:0] sec_idx;
  logic              sec_high;

  hi_state_t         state_q, state_d;
  logic [RUN_W-1:0]  run_len_q, run_len_d, run_inc;
  logic [HI_W-1:0]   hi_d;

  sec_timebase #(.CLK_HZ(CLK_HZ)) u_timebase (
    .pulseBase (pulseBase),
    .resetN    (resetN),
    .secTick   (secTick)
  );

  assign step_edge = pulseIn & ~pulse_q;
  // A step landing on the tick cycle still belongs to the second that is ending.
  assign sec_total = {1'b0, sec_steps} + {{SEC_W{1'b0}}, step_edge};
  assign sec_high  = (sec_total >= HI_THR);
  assign run_inc   = (run_len_q == {RUN_W{1'b1}}) ? run_len_q : run_len_q + 1'b1;

  always_ff @(posedge pulseBase) begin
    if (!resetN) begin
      pulse_q       <= 1'b1;
      stepCount     <= '0;
      residue       <= '0;
      distHalfMiles <= '0;
      sec_steps     <= '0;
      sec_idx       <= '0;
      overSecs      <= '0;
    end else begin
      pulse_q <= pulseIn;
      if (step_edge && (stepCount != STEP_MAX)) begin
        stepCount <= stepCount + 1'b1;
      end
      if (step_edge) begin
        if (residue == RES_LAST) begin
          residue <= '0;
          if (distHalfMiles != {DIST_W{1'b1}}) begin
            distHalfMiles <= distHalfMiles + 1'b1;
          end
        end else begin
          residue <= residue + 1'b1;
        end
      end
      if (secTick) begin
        sec_steps <= '0;
      end else if (step_edge && (sec_steps != {SEC_W{1'b1}})) begin
        sec_steps <= sec_steps + 1'b1;
      end
      if (secTick && (sec_idx < WIN_LEN)) begin
        sec_idx <= sec_idx + 1'b1;
        if (sec_total > OVER_THR) begin
          overSecs <= overSecs + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pulseBase) begin
    if (!resetN) begin
      state_q   <= IDLE;
      run_len_q <= '0;
      hiActSecs <= '0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      hiActSecs <= hi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    hi_d      = hiActSecs;
    if (secTick) begin
      unique case (state_q)
        IDLE: begin
          if (sec_high) begin
            run_len_d = RUN_W'(1);
            if (HI_MIN_SEC == 1) begin
              state_d = ACTIVE;
              hi_d    = sat_add_hi(hiActSecs, HI_CRED);
            end else begin
              state_d = PENDING;
            end
          end
        end
        PENDING: begin
          if (sec_high) begin
            run_len_d = run_inc;
            // The whole qualifying run is credited at once when it reaches length.
            if (run_inc == RUN_QUAL) begin
              hi_d    = sat_add_hi(hiActSecs, HI_CRED);
              state_d = ACTIVE;
            end
          end else begin
            run_len_d = '0;
            state_d   = IDLE;
          end
        end
        ACTIVE: begin
          if (sec_high) begin
            run_len_d = run_inc;
            hi_d      = sat_add_hi(hiActSecs, HI_W'(1));
          end else begin
            run_len_d = '0;
            state_d   = IDLE;
          end
        end
        default: begin
          run_len_d = '0;
          state_d   = IDLE;
        end
      endcase
    end
  end

endmodule
